// File: rtl/hack_uart_pkg.sv
// rtl/hack_uart_pkg.sv - shared UART TX constants, state codes and memory-map addresses
package hack_uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int STAT_FULL    = 0;
  localparam int STAT_BUSY    = 1;
  localparam int STAT_OVERRUN = 2;

  // Sits just above the keyboard register so Memory can decode both with one compare.
  localparam logic [15:0] ADDR_TX_DATA   = 16'h6001;
  localparam logic [15:0] ADDR_TX_STATUS = 16'h6002;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - byte-wide synchronous FIFO feeding the UART transmitter
module tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  localparam int PW = $clog2(FIFO_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic [7:0]    data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [PW:0]   count_o
);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == (PW+1)'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Guard here too so a careless caller can never corrupt the pointers.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - memory-mapped 8N1 UART transmitter with status word
module uart_tx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_CLK,
  input  logic        i_RESET_n,
  input  logic [15:0] i_Data,
  input  logic        i_Write_EN,
  output logic [15:0] o_Status,
  output logic        o_Serial_TX
);

  import hack_uart_pkg::*;

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam int PW  = $clog2(FIFO_DEPTH);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovr_q, ovr_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_data;
  logic [PW:0]   fifo_count;
  logic          baud_done;
  logic          unused_data_hi;

  assign unused_data_hi = ^i_Data[15:8];
  assign fifo_push      = i_Write_EN & ~fifo_full;
  assign ovr_d          = ovr_q | (i_Write_EN & fifo_full);
  assign baud_done      = (baud_q == CW'(CPB - 1));

  tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (i_CLK),
    .rst_ni  (i_RESET_n),
    .push_i  (fifo_push),
    .data_i  (i_Data[7:0]),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    baud_d   = baud_done ? '0 : baud_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_done) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      default: begin
        // Chain straight into the next start bit so queued frames stay contiguous.
        if (baud_done) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_data;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    o_Status               = '0;
    o_Status[STAT_FULL]    = fifo_full;
    o_Status[STAT_BUSY]    = (state_q != ST_IDLE) | (fifo_count != '0);
    o_Status[STAT_OVERRUN] = ovr_q;
  end

  assign o_Serial_TX = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-timing reference model
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data;
  logic        wen;
  logic [15:0] status;
  logic        tx;

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(1000), .BAUD(250), .FIFO_DEPTH(DEPTH)) dut (
    .i_CLK       (clk),
    .i_RESET_n   (rst_n),
    .i_Data      (data),
    .i_Write_EN  (wen),
    .o_Status    (status),
    .o_Serial_TX (tx)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: bytes waiting in the FIFO, plus the edge at which the current frame started.
  int         e;
  logic [7:0] q[$];
  int         frame_start;
  int         next_start;
  logic [7:0] cur;
  logic       m_ovr;

  function automatic logic in_frame();
    return (e - frame_start) < FRAME;
  endfunction

  function automatic logic exp_line();
    int c, k;
    if (!in_frame()) return 1'b1;
    c = e - frame_start;
    k = c / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return cur[k-1];
    return 1'b1;
  endfunction

  function automatic logic [15:0] exp_status();
    logic [15:0] s;
    s    = '0;
    s[0] = (q.size() == DEPTH);
    s[1] = (q.size() > 0) || in_frame();
    s[2] = m_ovr;
    return s;
  endfunction

  task automatic model_reset();
    q.delete();
    frame_start = -1000;
    next_start  = 0;
    cur         = '0;
    m_ovr       = 1'b0;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  // Called at a falling edge: drive, clock once, update the model, then compare.
  task automatic step(input bit w, input logic [15:0] d);
    bit full_before;
    wen  = w;
    data = d;
    @(posedge clk);
    e++;
    full_before = (q.size() == DEPTH);
    if (q.size() > 0 && e >= next_start) begin
      cur         = q.pop_front();
      frame_start = e;
      next_start  = e + FRAME;
    end
    if (w) begin
      if (full_before) m_ovr = 1'b1;
      else q.push_back(d[7:0]);
    end
    @(negedge clk);
    wen = 1'b0;
    check("line", {15'b0, tx}, {15'b0, exp_line()});
    check("status", status, exp_status());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_line"}, {15'b0, tx}, 16'h0001);
    check({tag, "_status"}, status, 16'h0000);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    wen   = 1'b0;
    data  = '0;
    e     = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_line", {15'b0, tx}, 16'h0001);
    check("reset_status", status, 16'h0000);
    rst_n = 1'b1;

    idle(100);

    step(1'b1, 16'h1255);
    idle(45);

    step(1'b1, 16'h0000);
    step(1'b1, 16'h00FF);
    idle(90);

    for (int i = 1; i <= 6; i++) step(1'b1, 16'(i));
    check("full_after_burst", {15'b0, status[0]}, 16'h0001);
    check("ovr_after_burst", {15'b0, status[2]}, 16'h0001);
    idle(220);
    check("ovr_sticky", {15'b0, status[2]}, 16'h0001);

    @(negedge clk);
    do_reset("rst2");
    for (int i = 1; i <= 5; i++) step(1'b1, 16'(8'h20 + i));
    for (int i = 0; i < 2 * FRAME && e + 1 < next_start; i++) step(1'b0, 16'h0000);
    step(1'b1, 16'h0077);
    check("ovr_pop_edge", {15'b0, status[2]}, 16'h0001);
    idle(210);

    do_reset("rst3");
    step(1'b1, 16'h00A5);
    for (int i = 0; i < 30 && !((e - frame_start) >= 17 && in_frame()); i++) step(1'b0, 16'h0000);
    do_reset("rst_midframe");
    step(1'b1, 16'h003C);
    idle(45);

    for (int i = 0; i < 400; i++) step(($urandom_range(0, 3) == 0), 16'($urandom));
    idle(220);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
